// File: rtl/midi_channel_frontend_if.sv
// midi_channel_frontend_if: MIDI line in, assembled messages and per-channel note state out
interface midi_channel_frontend_if;
  logic         MIDI_in;
  logic [23:0]  MIDI_data;
  logic         msg_valid;
  logic [127:0] ch_data;
  logic [191:0] pitch;
  logic         frame_err;
  modport master (output MIDI_in, input MIDI_data, msg_valid, ch_data, pitch, frame_err);
  modport slave  (input MIDI_in, output MIDI_data, msg_valid, ch_data, pitch, frame_err);
endinterface

// File: rtl/midi_channel_frontend.sv
// midi_channel_frontend: MIDI UART receiver, channel message assembler, 8-channel note
// registers and note-to-half-period conversion for the stepper synth.
module midi_channel_frontend #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 31250
) (
  input logic Clk,
  input logic Rst_n,
  midi_channel_frontend_if.slave bus
);
  localparam int BIT_CLKS = CLK_HZ / BAUD;
  localparam logic [15:0] FULL = 16'(BIT_CLKS - 1);
  localparam logic [15:0] HALF = 16'(BIT_CLKS / 2 - 1);
  function automatic logic [23:0] t_of(input real f);
    return 24'($rtoi(real'(CLK_HZ) / (2.0 * f) + 0.5));
  endfunction
  // Half-period counts for octave -1 (MIDI notes 0..11); higher octaves shift right
  localparam logic [11:0][23:0] T = {
    t_of(15.4338531643), t_of(14.5676175474), t_of(13.75),         t_of(12.9782717994),
    t_of(12.2498573744), t_of(11.5623257097), t_of(10.9133822323), t_of(10.3008611535),
    t_of(9.72271824132), t_of(9.17702399742), t_of(8.66195721803), t_of(8.17579891564)};
  function automatic logic [23:0] pitch_of(input logic [6:0] n, input logic [7:0] v);
    return v == 8'd0 ? 24'd0 : T[4'(n % 7'd12)] >> (n / 7'd12);
  endfunction
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t           r_state;
  logic [1:0]       r_sync;
  logic             r_rx_d;
  logic [15:0]      r_cnt;
  logic [2:0]       r_bits;
  logic [7:0]       r_shift;
  logic             r_frame_err;
  logic [7:0]       r_status;
  logic             r_rs_valid;
  logic             r_have_d1;
  logic [7:0]       r_d1;
  logic [23:0]      r_data;
  logic             r_msg_valid;
  logic [7:0][15:0] r_ch;
  logic [7:0][23:0] r_pitch;
  logic             w_rx;
  logic             w_byte_ok;
  logic             w_route;
  logic [3:0]       w_cmd;
  logic [2:0]       w_chn;
  assign w_rx      = r_sync[1];
  assign w_byte_ok = r_state == STOP && r_cnt == FULL && w_rx;
  assign w_cmd     = r_data[23:20];
  assign w_chn     = r_data[18:16];
  assign w_route   = r_msg_valid && !r_data[19];
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= IDLE;
      r_sync      <= 2'b11;
      r_rx_d      <= 1'b1;
      r_cnt       <= '0;
      r_bits      <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], bus.MIDI_in};
      r_rx_d      <= w_rx;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: if (r_rx_d && !w_rx) begin
          r_state <= START;
          r_cnt   <= '0;
        end
        START: if (r_cnt == HALF) begin
          r_state <= w_rx ? IDLE : DATA;
          r_cnt   <= '0;
          r_bits  <= '0;
        end else r_cnt <= r_cnt + 16'd1;
        DATA: if (r_cnt == FULL) begin
          r_cnt   <= '0;
          r_shift <= {w_rx, r_shift[7:1]};
          r_bits  <= r_bits + 3'd1;
          if (r_bits == 3'd7) r_state <= STOP;
        end else r_cnt <= r_cnt + 16'd1;
        STOP: if (r_cnt == FULL) begin
          r_state     <= IDLE;
          r_frame_err <= !w_rx;
        end else r_cnt <= r_cnt + 16'd1;
        default: r_state <= IDLE;
      endcase
    end
  end
  // The assembler consumes the byte on the stop-sample edge so results appear the next cycle
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_status    <= '0;
      r_rs_valid  <= 1'b0;
      r_have_d1   <= 1'b0;
      r_d1        <= '0;
      r_data      <= '0;
      r_msg_valid <= 1'b0;
    end else begin
      r_msg_valid <= 1'b0;
      if (w_byte_ok && r_shift < 8'hF8) begin
        if (r_shift[7]) begin
          r_status   <= r_shift;
          r_rs_valid <= r_shift < 8'hF0;
          r_have_d1  <= 1'b0;
        end else if (r_rs_valid && !r_have_d1) begin
          r_d1      <= r_shift;
          r_have_d1 <= 1'b1;
        end else if (r_rs_valid) begin
          r_data      <= {r_status, r_d1, r_shift};
          r_msg_valid <= 1'b1;
          r_have_d1   <= 1'b0;
        end
      end
    end
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_ch    <= '0;
      r_pitch <= '0;
    end else begin
      if (w_route && w_cmd == 4'h9 && r_data[7:0] != 8'd0)
        r_ch[w_chn] <= r_data[15:0];
      else if (w_route && (w_cmd == 4'h8 || w_cmd == 4'h9) && r_ch[w_chn][15:8] == r_data[15:8])
        r_ch[w_chn] <= 16'd0;
      for (int k = 0; k < 8; k++) r_pitch[k] <= pitch_of(r_ch[k][14:8], r_ch[k][7:0]);
    end
  end
  assign bus.MIDI_data = r_data;
  assign bus.msg_valid = r_msg_valid;
  assign bus.ch_data   = r_ch;
  assign bus.pitch     = r_pitch;
  assign bus.frame_err = r_frame_err;
endmodule

// File: tb/tb_midi_channel_frontend.sv
// tb_midi_channel_frontend: directed MIDI byte stream with a message scoreboard checking
// MIDI_data, then ch_data one cycle later and pitch two cycles later.
module tb_midi_channel_frontend;
  localparam int BIT = 10;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  midi_channel_frontend_if bus();
  // Fast baud keeps bytes short; the pitch table depends only on CLK_HZ
  midi_channel_frontend #(.CLK_HZ(50_000_000), .BAUD(5_000_000)) dut (
    .Clk(clk), .Rst_n(rst_n), .bus(bus));
  typedef struct packed {
    logic [23:0]  data;
    logic [127:0] ch;
    logic [191:0] p;
  } exp_t;
  exp_t        q[$];
  logic [15:0] m_ch[8];
  logic [23:0] m_p[8];
  int n_cmp = 0;
  int n_bad = 0;
  int n_ferr = 0;
  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic push_exp(input logic [23:0] d);
    exp_t e;
    e.data = d;
    for (int k = 0; k < 8; k++) begin
      e.ch[16*k +: 16] = m_ch[k];
      e.p[24*k +: 24]  = m_p[k];
    end
    q.push_back(e);
  endtask
  task automatic send(input logic [7:0] b, input logic stop = 1'b1);
    bus.MIDI_in = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.MIDI_in = b[i];
      repeat (BIT) @(negedge clk);
    end
    bus.MIDI_in = stop;
    repeat (BIT) @(negedge clk);
    bus.MIDI_in = 1'b1;
  endtask
  always begin
    @(negedge clk);
    if (bus.msg_valid) begin
      exp_t e;
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL msg_valid: got unexpected pulse data=%h expected none", bus.MIDI_data);
      end else begin
        e = q.pop_front();
        check("MIDI_data", 192'(bus.MIDI_data), 192'(e.data));
        @(negedge clk);
        check("ch_data", 192'(bus.ch_data), 192'(e.ch));
        @(negedge clk);
        check("pitch", bus.pitch, e.p);
      end
    end
  end
  always @(negedge clk) if (bus.frame_err) n_ferr++;
  initial begin
    bus.MIDI_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      m_ch[k] = '0;
      m_p[k]  = '0;
    end
    repeat (5) @(negedge clk);
    check("reset MIDI_data", 192'(bus.MIDI_data), '0);
    check("reset ch_data", 192'(bus.ch_data), '0);
    check("reset pitch", bus.pitch, '0);
    check("reset msg_valid", 192'(bus.msg_valid), '0);
    check("reset frame_err", 192'(bus.frame_err), '0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    m_ch[5] = 16'h4520; m_p[5] = 24'd56818;
    push_exp(24'h954520);
    send(8'h95); send(8'h45); send(8'h20);
    repeat (2 * BIT) @(negedge clk);
    bus.MIDI_in = 1'b0;
    repeat (4 * BIT) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset MIDI_data", 192'(bus.MIDI_data), '0);
    check("midreset ch_data", 192'(bus.ch_data), '0);
    check("midreset pitch", bus.pitch, '0);
    check("midreset msg_valid", 192'(bus.msg_valid), '0);
    bus.MIDI_in = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      m_ch[k] = '0;
      m_p[k]  = '0;
    end
    repeat (20) @(negedge clk);
    m_ch[0] = 16'h4564; m_p[0] = 24'd56818;
    push_exp(24'h904564);
    send(8'h90); send(8'h45); send(8'h64);
    m_ch[3] = 16'h3C40; m_p[3] = 24'd95556;
    push_exp(24'h933C40);
    send(8'h93); send(8'h3C); send(8'h40);
    push_exp(24'h933D00);
    send(8'h93); send(8'h3D); send(8'h00);
    m_ch[3] = 16'h0000; m_p[3] = 24'd0;
    push_exp(24'h833C00);
    send(8'h83); send(8'h3C); send(8'h00);
    m_ch[1] = 16'h3010; m_p[1] = 24'd191112;
    push_exp(24'h913010);
    m_ch[1] = 16'h3220; m_p[1] = 24'd170262;
    push_exp(24'h913220);
    send(8'h91); send(8'h30); send(8'h10); send(8'h32); send(8'h20);
    push_exp(24'h994564);
    send(8'h99); send(8'h45); send(8'h64);
    m_ch[0] = 16'h407F; m_p[0] = 24'd75843;
    push_exp(24'h90407F);
    send(8'h90); send(8'hF8); send(8'h40); send(8'h7F);
    m_ch[1] = 16'h3010; m_p[1] = 24'd191112;
    push_exp(24'h913010);
    send(8'h91); send(8'h30);
    send(8'h55, 1'b0);
    repeat (BIT) @(negedge clk);
    send(8'h10);
    bus.MIDI_in = 1'b0;
    repeat (3) @(negedge clk);
    bus.MIDI_in = 1'b1;
    repeat (BIT) @(negedge clk);
    m_ch[2] = 16'h4511; m_p[2] = 24'd56818;
    push_exp(24'h924511);
    send(8'h92); send(8'h45); send(8'h11);
    repeat (4 * BIT) @(negedge clk);
    check("scoreboard drained", 192'(q.size()), '0);
    check("frame_err pulses", 192'(n_ferr), 192'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
